// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Width of the step counter that walks p_width-1 down to 0.
    function automatic int count_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/divide_seq_if.sv
// Request/response bundle of the iterative divider, plus a debug view of its FSM.
// Request moves on an edge where valid_i & ready_o; result moves on an edge where valid_o & ready_i.
interface divide_seq_if
    import div_pkg::*;
#(
    parameter int p_width = 4
);
    logic               valid_i;
    logic               ready_o;
    logic [p_width-1:0] dividend_i;
    logic [p_width-1:0] divisor_i;
    logic               dividend_signed_i;
    logic               divisor_signed_i;
    logic               valid_o;
    logic               ready_i;
    logic [p_width-1:0] quotient_o;
    logic [p_width-1:0] remainder_o;
    logic               div_by_zero_o;
    state_e             state_o;

    modport slave (
        input  valid_i, dividend_i, divisor_i, dividend_signed_i, divisor_signed_i, ready_i,
        output ready_o, valid_o, quotient_o, remainder_o, div_by_zero_o, state_o
    );

    modport master (
        output valid_i, dividend_i, divisor_i, dividend_signed_i, divisor_signed_i, ready_i,
        input  ready_o, valid_o, quotient_o, remainder_o, div_by_zero_o, state_o
    );
endinterface

// File: rtl/div_step.sv
// One restoring division step: shift a dividend bit into the partial remainder and
// subtract the divisor when it fits.
module div_step #(
    parameter int p_width = 4
) (
    input  logic [p_width-1:0] rem_i,
    input  logic [p_width-1:0] divisor_i,
    input  logic               bit_i,
    output logic [p_width-1:0] rem_o,
    output logic               q_o
);
    logic [p_width:0] shifted;

    always_comb begin
        shifted = {rem_i, bit_i};
        q_o     = (shifted >= {1'b0, divisor_i});
        // When the subtraction is kept the result is below the divisor, so p_width bits suffice.
        rem_o   = q_o ? (shifted[p_width-1:0] - divisor_i) : shifted[p_width-1:0];
    end
endmodule

// File: rtl/divide_seq.sv
// Iterative signed/unsigned divider: magnitudes are divided MSB first, one restoring step
// per cycle, and signs are applied in a final fix-up cycle.
module divide_seq
    import div_pkg::*;
#(
    parameter int p_width = 4
) (
    input logic         clk_i,
    input logic         reset_i,
    divide_seq_if.slave bus
);
    localparam int cnt_w = count_width(p_width);

    state_e             state_q, state_d;
    logic [cnt_w-1:0]   count_q, count_d;
    logic [p_width-1:0] rem_q, rem_d;
    logic [p_width-1:0] quo_q, quo_d;
    logic [p_width-1:0] div_q, div_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic               dbz_q, dbz_d;
    logic [p_width-1:0] quotient_q, quotient_d;
    logic [p_width-1:0] remainder_q, remainder_d;
    logic               dbz_out_q, dbz_out_d;

    logic               neg_dd, neg_dv;
    logic [p_width-1:0] mag_dd, mag_dv;
    logic [p_width-1:0] step_rem;
    logic               step_bit;

    div_step #(.p_width(p_width)) u_step (
        .rem_i     (rem_q),
        .divisor_i (div_q),
        .bit_i     (quo_q[p_width-1]),
        .rem_o     (step_rem),
        .q_o       (step_bit)
    );

    always_comb begin
        neg_dd = bus.dividend_signed_i & bus.dividend_i[p_width-1];
        neg_dv = bus.divisor_signed_i & bus.divisor_i[p_width-1];
        mag_dd = neg_dd ? -bus.dividend_i : bus.dividend_i;
        mag_dv = neg_dv ? -bus.divisor_i : bus.divisor_i;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        dbz_d       = dbz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_out_d   = dbz_out_q;
        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    rem_d   = '0;
                    quo_d   = mag_dd;
                    div_d   = mag_dv;
                    neg_q_d = neg_dd ^ neg_dv;
                    neg_r_d = neg_dd;
                    dbz_d   = (bus.divisor_i == '0);
                    count_d = cnt_w'(p_width - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                // quo_q shifts dividend bits out of its top while quotient bits enter at the bottom.
                rem_d   = step_rem;
                quo_d   = {quo_q[p_width-2:0], step_bit};
                count_d = count_q - cnt_w'(1);
                if (count_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // With a zero divisor the negated magnitude remainder already equals the raw dividend.
                quotient_d  = dbz_q ? '1 : (neg_q_q ? -quo_q : quo_q);
                remainder_d = neg_r_q ? -rem_q : rem_q;
                dbz_out_d   = dbz_q;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_out_q   <= dbz_out_d;
        end
    end

    assign bus.ready_o       = (state_q == IDLE) && !reset_i;
    assign bus.valid_o       = (state_q == DONE);
    assign bus.quotient_o    = quotient_q;
    assign bus.remainder_o   = remainder_q;
    assign bus.div_by_zero_o = dbz_out_q;
    assign bus.state_o       = state_q;
endmodule
